// File: rtl/rf_wb_arbiter_if.sv
// Bundles the three producer result channels and the register-file write channel of the write-back arbiter.
// master = producer/environment side, slave = arbiter side.
interface rf_wb_arbiter_if #(
    parameter int TAG_WIDTH = 2
);
    logic                 src0_valid;
    logic                 src0_ready;
    logic [4:0]           src0_addr;
    logic [TAG_WIDTH-1:0] src0_tag;
    logic [31:0]          src0_data;

    logic                 src1_valid;
    logic                 src1_ready;
    logic [4:0]           src1_addr;
    logic [TAG_WIDTH-1:0] src1_tag;
    logic [31:0]          src1_data;

    logic                 src2_valid;
    logic                 src2_ready;
    logic [4:0]           src2_addr;
    logic [TAG_WIDTH-1:0] src2_tag;
    logic [31:0]          src2_data;

    logic                 wr_ch0_en;
    logic [4:0]           wr_ch0_addr;
    logic [TAG_WIDTH-1:0] wr_ch0_tag;
    logic [31:0]          wr_ch0_data;
    logic                 wb_busy;

    modport master (
        output src0_valid, src0_addr, src0_tag, src0_data,
        output src1_valid, src1_addr, src1_tag, src1_data,
        output src2_valid, src2_addr, src2_tag, src2_data,
        input  src0_ready, src1_ready, src2_ready,
        input  wr_ch0_en, wr_ch0_addr, wr_ch0_tag, wr_ch0_data, wb_busy
    );

    modport slave (
        input  src0_valid, src0_addr, src0_tag, src0_data,
        input  src1_valid, src1_addr, src1_tag, src1_data,
        input  src2_valid, src2_addr, src2_tag, src2_data,
        output src0_ready, src1_ready, src2_ready,
        output wr_ch0_en, wr_ch0_addr, wr_ch0_tag, wr_ch0_data, wb_busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Three-source write-back arbiter onto the single register-file write port; round-robin when RF_WB_RR_EN is defined, else fixed src0 > src1 > src2.
// Latency 2 cycles valid->wr_ch0_en; srcN_ready drops only while entry N waits ungranted.
module rf_wb_arbiter #(
    parameter int TAG_WIDTH = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int NSRC = 3;

    logic [NSRC-1:0]      w_src_vld;
    logic [4:0]           w_src_addr [NSRC];
    logic [TAG_WIDTH-1:0] w_src_tag  [NSRC];
    logic [31:0]          w_src_data [NSRC];

    logic [NSRC-1:0]      r_hold_vld;
    logic [4:0]           r_hold_addr [NSRC];
    logic [TAG_WIDTH-1:0] r_hold_tag  [NSRC];
    logic [31:0]          r_hold_data [NSRC];

    logic [NSRC-1:0]      w_grant;
    logic [1:0]           w_win;
    logic [NSRC-1:0]      w_ready;
    logic [NSRC-1:0]      w_xfer;
    logic [NSRC-1:0]      w_load;

    logic                 r_wr_en;
    logic [4:0]           r_wr_addr;
    logic [TAG_WIDTH-1:0] r_wr_tag;
    logic [31:0]          r_wr_data;

    assign w_src_vld     = {bus.src2_valid, bus.src1_valid, bus.src0_valid};
    assign w_src_addr[0] = bus.src0_addr;
    assign w_src_addr[1] = bus.src1_addr;
    assign w_src_addr[2] = bus.src2_addr;
    assign w_src_tag[0]  = bus.src0_tag;
    assign w_src_tag[1]  = bus.src1_tag;
    assign w_src_tag[2]  = bus.src2_tag;
    assign w_src_data[0] = bus.src0_data;
    assign w_src_data[1] = bus.src1_data;
    assign w_src_data[2] = bus.src2_data;

`ifdef RF_WB_RR_EN
    logic [1:0] r_last;

    function automatic logic [1:0] rr_idx(input logic [1:0] last, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, last} + {1'b0, step};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // Search order last+1, last+2, last+3 (mod 3): the previous winner goes to the back.
    always_comb begin
        w_grant = '0;
        w_win   = 2'd0;
        for (int k = 1; k <= NSRC; k++) begin
            if ((w_grant == '0) && r_hold_vld[rr_idx(r_last, 2'(k))]) begin
                w_grant[rr_idx(r_last, 2'(k))] = 1'b1;
                w_win                          = rr_idx(r_last, 2'(k));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 2'd2;
        end else if (|w_grant) begin
            r_last <= w_win;
        end
    end
`else
    always_comb begin
        w_grant = '0;
        w_win   = 2'd0;
        if (r_hold_vld[0]) begin
            w_grant[0] = 1'b1;
            w_win      = 2'd0;
        end else if (r_hold_vld[1]) begin
            w_grant[1] = 1'b1;
            w_win      = 2'd1;
        end else if (r_hold_vld[2]) begin
            w_grant[2] = 1'b1;
            w_win      = 2'd2;
        end
    end
`endif

    // A granted entry frees up this cycle, so its producer can refill it without a bubble.
    assign w_ready = ~r_hold_vld | w_grant;
    assign w_xfer  = w_src_vld & w_ready;

    always_comb begin
        w_load = '0;
        for (int n = 0; n < NSRC; n++) begin
            w_load[n] = w_xfer[n] && (w_src_addr[n] != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_vld <= '0;
        end else begin
            r_hold_vld <= w_load | (r_hold_vld & ~w_grant);
        end
    end

    // Payload is only meaningful while r_hold_vld is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NSRC; n++) begin
            if (w_load[n]) begin
                r_hold_addr[n] <= w_src_addr[n];
                r_hold_tag[n]  <= w_src_tag[n];
                r_hold_data[n] <= w_src_data[n];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_tag  <= '0;
            r_wr_data <= 32'd0;
        end else begin
            r_wr_en <= |w_grant;
            if (|w_grant) begin
                r_wr_addr <= r_hold_addr[w_win];
                r_wr_tag  <= r_hold_tag[w_win];
                r_wr_data <= r_hold_data[w_win];
            end
        end
    end

    assign bus.src0_ready  = w_ready[0];
    assign bus.src1_ready  = w_ready[1];
    assign bus.src2_ready  = w_ready[2];
    assign bus.wr_ch0_en   = r_wr_en;
    assign bus.wr_ch0_addr = r_wr_addr;
    assign bus.wr_ch0_tag  = r_wr_tag;
    assign bus.wr_ch0_data = r_wr_data;
    assign bus.wb_busy     = (|r_hold_vld) | r_wr_en;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-cycle vector table, then streaming, fairness and mid-operation reset sequences.
module tb_rf_wb_arbiter;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.TAG_WIDTH(TW)) bus ();
    rf_wb_arbiter #(.TAG_WIDTH(TW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]      vld;
        logic [14:0]     a;
        logic [3*TW-1:0] t;
        logic [95:0]     d;
        logic [2:0]      rdy;
        logic            en;
        logic [4:0]      wa;
        logic [TW-1:0]   wt;
        logic [31:0]     wd;
        logic            busy;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [3*TW-1:0] t, input logic [95:0] d);
        bus.src0_valid = v[0];
        bus.src1_valid = v[1];
        bus.src2_valid = v[2];
        bus.src0_addr  = a[4:0];
        bus.src1_addr  = a[9:5];
        bus.src2_addr  = a[14:10];
        bus.src0_tag   = t[TW-1:0];
        bus.src1_tag   = t[2*TW-1:TW];
        bus.src2_tag   = t[3*TW-1:2*TW];
        bus.src0_data  = d[31:0];
        bus.src1_data  = d[63:32];
        bus.src2_data  = d[95:64];
    endtask

    function automatic vec_t row(input logic [2:0] vld, input logic [14:0] a, input logic [3*TW-1:0] t,
                                 input logic [95:0] d, input logic [2:0] rdy, input logic en,
                                 input logic [4:0] wa, input logic [TW-1:0] wt, input logic [31:0] wd,
                                 input logic busy);
        vec_t r;
        r.vld = vld; r.a = a; r.t = t; r.d = d; r.rdy = rdy;
        r.en = en; r.wa = wa; r.wt = wt; r.wd = wd; r.busy = busy;
        return r;
    endfunction

    function automatic logic [2:0] rdy_vec();
        return {bus.src2_ready, bus.src1_ready, bus.src0_ready};
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sq[$];
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        int nwr, first_wr, last_wr, d0, d1, nf;
        logic [4:0] ea;

        // single transfer (rows 1-4), three-way collision (5-10), x0 discard (11-14)
        vec[0]  = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
        vec[1]  = row(3'b010, {5'd0, 5'd5, 5'd0}, {2'd0, 2'd1, 2'd0}, {32'd0, 32'hDEADBEEF, 32'd0},
                      3'b111, 1'b0, 5'd0, 2'd0, 32'd0, 1'b0);
        vec[2]  = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b0, 5'd0, 2'd0, 32'd0, 1'b1);
        vec[3]  = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b1, 5'd5, 2'd1, 32'hDEADBEEF, 1'b1);
        vec[4]  = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b0, 5'd5, 2'd1, 32'hDEADBEEF, 1'b0);
        vec[5]  = row(3'b111, {5'd3, 5'd2, 5'd1}, {2'd2, 2'd1, 2'd0}, {32'h33, 32'h22, 32'h11},
                      3'b111, 1'b0, 5'd5, 2'd1, 32'hDEADBEEF, 1'b0);
        vec[6]  = row(3'b000, 15'd0, '0, 96'd0, 3'b001, 1'b0, 5'd5, 2'd1, 32'hDEADBEEF, 1'b1);
        vec[7]  = row(3'b000, 15'd0, '0, 96'd0, 3'b011, 1'b1, 5'd1, 2'd0, 32'h11, 1'b1);
        vec[8]  = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b1, 5'd2, 2'd1, 32'h22, 1'b1);
        vec[9]  = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b1, 5'd3, 2'd2, 32'h33, 1'b1);
        vec[10] = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b0, 5'd3, 2'd2, 32'h33, 1'b0);
        vec[11] = row(3'b001, 15'd0, {2'd0, 2'd0, 2'd3}, {64'd0, 32'hBAD},
                      3'b111, 1'b0, 5'd3, 2'd2, 32'h33, 1'b0);
        for (int i = 12; i < 15; i++) begin
            vec[i] = row(3'b000, 15'd0, '0, 96'd0, 3'b111, 1'b0, 5'd3, 2'd2, 32'h33, 1'b0);
        end

        drive(3'b000, 15'd0, '0, 96'd0);
        #3;
        check("reset_rdy", 64'(rdy_vec()), 64'h7);
        check("reset_en", 64'(bus.wr_ch0_en), 64'd0);
        check("reset_addr", 64'(bus.wr_ch0_addr), 64'd0);
        check("reset_tag", 64'(bus.wr_ch0_tag), 64'd0);
        check("reset_data", 64'(bus.wr_ch0_data), 64'd0);
        check("reset_busy", 64'(bus.wb_busy), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vec[i].vld, vec[i].a, vec[i].t, vec[i].d);
            @(negedge clk);
            check($sformatf("vec%0d_rdy", i), 64'(rdy_vec()), 64'(vec[i].rdy));
            check($sformatf("vec%0d_en", i), 64'(bus.wr_ch0_en), 64'(vec[i].en));
            check($sformatf("vec%0d_addr", i), 64'(bus.wr_ch0_addr), 64'(vec[i].wa));
            check($sformatf("vec%0d_tag", i), 64'(bus.wr_ch0_tag), 64'(vec[i].wt));
            check($sformatf("vec%0d_data", i), 64'(bus.wr_ch0_data), 64'(vec[i].wd));
            check($sformatf("vec%0d_busy", i), 64'(bus.wb_busy), 64'(vec[i].busy));
            @(posedge clk);
            #1;
        end

        // streaming: src2 alone, 8 consecutive transfers
        nwr = 0; first_wr = -1; last_wr = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(3'b100, {5'd7, 10'd0}, {2'd3, 4'd0}, {32'(c), 64'd0});
            else       drive(3'b000, 15'd0, '0, 96'd0);
            @(negedge clk);
            if (c < 8) begin
                check("stream_rdy", 64'(bus.src2_ready), 64'd1);
                if (bus.src2_ready) sq.push_back(32'(c));
            end
            if (bus.wr_ch0_en) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                nwr++;
                check("stream_addr", 64'(bus.wr_ch0_addr), 64'd7);
                check("stream_q_nonempty", 64'(sq.size() > 0), 64'd1);
                if (sq.size() > 0) check("stream_data", 64'(bus.wr_ch0_data), 64'(sq.pop_front()));
            end
            @(posedge clk);
            #1;
        end
        check("stream_nwr", 64'(nwr), 64'd8);
        check("stream_first", 64'(first_wr), 64'd2);
        check("stream_b2b", 64'(last_wr - first_wr), 64'd7);
        check("stream_q_empty", 64'(sq.size()), 64'd0);

        // fairness: src0 and src1 valid every cycle
        d0 = 0; d1 = 0; nf = 0;
        for (int c = 0; c < 28; c++) begin
            if (c < 20) drive(3'b011, {5'd0, 5'd11, 5'd10}, '0, {32'd0, 32'(32'h100 + d1), 32'(d0)});
            else        drive(3'b000, 15'd0, '0, 96'd0);
            @(negedge clk);
            if (c < 20 && bus.src0_ready) begin q0.push_back(32'(d0)); d0++; end
            if (c < 20 && bus.src1_ready) begin q1.push_back(32'(32'h100 + d1)); d1++; end
            if (bus.wr_ch0_en) begin
                if (nf < 12) begin
`ifdef RF_WB_RR_EN
                    ea = (nf % 2 == 0) ? 5'd10 : 5'd11;
`else
                    ea = 5'd10;
`endif
                    check($sformatf("fair_addr%0d", nf), 64'(bus.wr_ch0_addr), 64'(ea));
                end else begin
                    ea = bus.wr_ch0_addr;
                end
                if (ea == 5'd11) begin
                    check("fair_q1_nonempty", 64'(q1.size() > 0), 64'd1);
                    if (q1.size() > 0) check("fair_data1", 64'(bus.wr_ch0_data), 64'(q1.pop_front()));
                end else begin
                    check("fair_q0_nonempty", 64'(q0.size() > 0), 64'd1);
                    if (q0.size() > 0) check("fair_data0", 64'(bus.wr_ch0_data), 64'(q0.pop_front()));
                end
                nf++;
            end
            @(posedge clk);
            #1;
        end
        check("fair_nwr_ge12", 64'(nf >= 12), 64'd1);
        check("fair_q0_empty", 64'(q0.size()), 64'd0);
        check("fair_q1_empty", 64'(q1.size()), 64'd0);

        // reset while three entries are pending and a write is in flight
        drive(3'b111, {5'd3, 5'd2, 5'd1}, '0, {32'h3, 32'h2, 32'h1});
        @(posedge clk);
        #1 drive(3'b000, 15'd0, '0, 96'd0);
        @(posedge clk);
        #1;
        check("rst_pre_en", 64'(bus.wr_ch0_en), 64'd1);
        check("rst_pre_busy", 64'(bus.wb_busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_en", 64'(bus.wr_ch0_en), 64'd0);
        check("rst_busy", 64'(bus.wb_busy), 64'd0);
        check("rst_rdy", 64'(rdy_vec()), 64'h7);
        check("rst_addr", 64'(bus.wr_ch0_addr), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_no_write", 64'(bus.wr_ch0_en), 64'd0);
            check("rst_idle_busy", 64'(bus.wb_busy), 64'd0);
            check("rst_idle_rdy", 64'(rdy_vec()), 64'h7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
